// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter
// Brief    : Round-robin arbiter sharing one data-memory port between two
//            masters, with fixed write latency and read timeout.
// Revision : 1.0
// ============================================================================
module dm_arbiter #(
    parameter int data_size = 32,
    parameter int addr_bit  = 12,
    parameter int WR_LAT    = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 m0_req,
    input  logic                 m0_write,
    input  logic [addr_bit-1:0]  m0_addr,
    input  logic [data_size-1:0] m0_wdata,
    output logic [data_size-1:0] m0_rdata,
    output logic                 m0_ack,
    output logic                 m0_err,

    input  logic                 m1_req,
    input  logic                 m1_write,
    input  logic [addr_bit-1:0]  m1_addr,
    input  logic [data_size-1:0] m1_wdata,
    output logic [data_size-1:0] m1_rdata,
    output logic                 m1_ack,
    output logic                 m1_err,

    output logic                 DM_enable,
    output logic                 DM_read,
    output logic                 DM_write,
    output logic [addr_bit-1:0]  DM_address,
    output logic [data_size-1:0] DM_in,
    input  logic [data_size-1:0] DM_out,
    input  logic                 DM_ready
);

    localparam int c_CNT_MAX = (TIMEOUT > WR_LAT) ? TIMEOUT : WR_LAT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_RD_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LAST = c_CNT_W'(WR_LAT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_RD = 3'd2,
        WAIT_WR = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic                   r_ptr;
    logic                   r_gnt;
    logic                   r_write;
    logic [addr_bit-1:0]    r_addr;
    logic [data_size-1:0]   r_wdata;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [data_size-1:0]   r_rdata [2];
    logic                   r_err   [2];

    logic                   w_grant;
    logic                   w_sel;
    logic                   w_rd_accept;
    logic                   w_rd_tmo;
    logic                   w_wr_done;
    logic                   w_issue;
    logic                   w_done;

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_grant     = 1'b0;
        w_sel       = r_gnt;
        w_rd_accept = 1'b0;
        w_rd_tmo    = 1'b0;
        w_wr_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    w_grant = 1'b1;
                    // On a tie the master not served last wins.
                    w_sel   = (m0_req && m1_req) ? ~r_ptr : m1_req;
                    w_next  = ISSUE;
                end
            end
            ISSUE: begin
                w_next = r_write ? WAIT_WR : WAIT_RD;
            end
            WAIT_RD: begin
                // DM_ready may still be stale from the previous access in the first cycle.
                if (r_cnt != '0 && DM_ready) begin
                    w_rd_accept = 1'b1;
                    w_next      = DONE;
                end else if (r_cnt == c_RD_LAST) begin
                    w_rd_tmo = 1'b1;
                    w_next   = DONE;
                end
            end
            WAIT_WR: begin
                if (r_cnt == c_WR_LAST) begin
                    w_wr_done = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        // Strobes and acks are gated by reset so an abandoned access stops at once.
        w_issue   = (r_state == ISSUE) && !reset;
        w_done    = (r_state == DONE) && !reset;
        DM_enable = w_issue;
        DM_read   = w_issue && !r_write;
        DM_write  = w_issue && r_write;
        m0_ack    = w_done && !r_gnt;
        m1_ack    = w_done && r_gnt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr      <= 1'b1;
            r_gnt      <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_rdata[0] <= '0;
            r_rdata[1] <= '0;
            r_err[0]   <= 1'b0;
            r_err[1]   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_ptr <= w_sel;
                r_gnt <= w_sel;
                if (w_sel) begin
                    r_write <= m1_write;
                    r_addr  <= m1_addr;
                    r_wdata <= m1_wdata;
                end else begin
                    r_write <= m0_write;
                    r_addr  <= m0_addr;
                    r_wdata <= m0_wdata;
                end
            end

            if ((r_state == WAIT_RD || r_state == WAIT_WR) && w_next == r_state)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;

            if (w_rd_accept) begin
                r_rdata[r_gnt] <= DM_out;
                r_err[r_gnt]   <= 1'b0;
            end else if (w_rd_tmo) begin
                r_err[r_gnt]   <= 1'b1;
            end else if (w_wr_done) begin
                r_err[r_gnt]   <= 1'b0;
            end
        end
    end

    assign DM_address = r_addr;
    assign DM_in      = r_wdata;
    assign m0_rdata   = r_rdata[0];
    assign m1_rdata   = r_rdata[1];
    assign m0_err     = r_err[0];
    assign m1_err     = r_err[1];

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_arbiter
// Brief    : Scoreboard bench for dm_arbiter with a behavioural memory model.
// Revision : 1.0
// ============================================================================
module tb_dm_arbiter;

    localparam int DW      = 32;
    localparam int AW      = 12;
    localparam int WR_LAT  = 3;
    localparam int TIMEOUT = 15;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [1:0]     req   = 2'b00;
    logic [1:0]     wr    = 2'b00;
    logic [AW-1:0]  ad [2];
    logic [DW-1:0]  wd [2];
    logic [DW-1:0]  DM_out   = '0;
    logic           DM_ready = 1'b1;

    wire  [DW-1:0]  m0_rdata, m1_rdata, DM_in;
    wire            m0_ack, m1_ack, m0_err, m1_err;
    wire            DM_enable, DM_read, DM_write;
    wire  [AW-1:0]  DM_address;

    dm_arbiter #(.data_size(DW), .addr_bit(AW), .WR_LAT(WR_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .m0_req(req[0]), .m0_write(wr[0]), .m0_addr(ad[0]), .m0_wdata(wd[0]),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(req[1]), .m1_write(wr[1]), .m1_addr(ad[1]), .m1_wdata(wd[1]),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
        .DM_address(DM_address), .DM_in(DM_in), .DM_out(DM_out), .DM_ready(DM_ready)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        int          ack_cyc;
        logic        err;
        logic [DW-1:0] rdata;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            rst_cyc = 0;
    exp_t          exp_q [2][$];
    int            grant_log [$];
    logic [DW-1:0] mem [16];
    logic [DW-1:0] model_rdata [2];
    logic          model_err [2];
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_din  = '0;
    logic [1:0]    prev_req  = 2'b00;
    int            last_g    = 1;
    int            force_k   = -1;
    int            rd_issue  = 0;
    int            rd_k      = 0;
    logic [DW-1:0] rd_data   = '0;
    logic          t_wr [2];
    logic [AW-1:0] t_addr [2];
    logic [DW-1:0] t_wd [2];
    logic          issued [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic ack_of(input int m);
        return (m != 0) ? m1_ack : m0_ack;
    endfunction
    function automatic logic err_of(input int m);
        return (m != 0) ? m1_err : m0_err;
    endfunction
    function automatic logic [DW-1:0] rdata_of(input int m);
        return (m != 0) ? m1_rdata : m0_rdata;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: read data appears k cycles into the wait (k=1000 means never).
    initial forever begin
        @(posedge clock);
        #1;
        if (rd_k != 0 && (cyc - rd_issue) < rd_k) begin
            DM_ready = 1'b0;
            DM_out   = $urandom;
        end else begin
            DM_ready = 1'b1;
            DM_out   = rd_data;
        end
    end

    // Monitor: predicts grants and completions, compares at each falling edge.
    always @(negedge clock) begin : mon
        int   g, k, w;
        exp_t e;
        if (reset) begin
            check("rst_strobes", 64'({DM_enable, DM_read, DM_write, m0_ack, m1_ack}), 64'(0));
            if (rst_cyc > 0) begin
                check("rst_rdata0", 64'(m0_rdata), 64'(0));
                check("rst_rdata1", 64'(m1_rdata), 64'(0));
                check("rst_err", 64'({m0_err, m1_err}), 64'(0));
                check("rst_addr", 64'(DM_address), 64'(0));
                check("rst_din", 64'(DM_in), 64'(0));
            end
            rst_cyc++;
            exp_q[0].delete();
            exp_q[1].delete();
            for (int m = 0; m < 2; m++) begin
                model_rdata[m] = '0;
                model_err[m]   = 1'b0;
            end
            last_g    = 1;
            last_addr = '0;
            last_din  = '0;
            rd_k      = 0;
        end else begin
            rst_cyc = 0;
            if (DM_enable) begin
                g = (prev_req == 2'b11) ? (1 - last_g) : (prev_req[1] ? 1 : 0);
                check("grant_has_req", 64'(prev_req != 2'b00), 64'(1));
                check("no_double_issue", 64'(exp_q[g].size()), 64'(0));
                check("dm_write", 64'(DM_write), 64'(t_wr[g]));
                check("dm_read", 64'(DM_read), 64'(!t_wr[g]));
                check("dm_addr", 64'(DM_address), 64'(t_addr[g]));
                check("dm_in", 64'(DM_in), 64'(t_wd[g]));
                last_g    = g;
                issued[g] = 1'b1;
                grant_log.push_back(g);
                last_addr = t_addr[g];
                last_din  = t_wd[g];
                if (t_wr[g]) begin
                    mem[t_addr[g][5:2]] = t_wd[g];
                    e.ack_cyc = cyc + WR_LAT + 1;
                    e.err     = 1'b0;
                    e.rdata   = model_rdata[g];
                end else begin
                    k = (force_k >= 0) ? force_k : int'($urandom_range(1, TIMEOUT + 3));
                    if (k == 0) k = 1000;
                    e.err     = (k > TIMEOUT);
                    w         = e.err ? TIMEOUT : ((k < 2) ? 2 : k);
                    e.ack_cyc = cyc + w + 1;
                    e.rdata   = e.err ? model_rdata[g] : mem[t_addr[g][5:2]];
                    rd_issue  = cyc;
                    rd_k      = k;
                    rd_data   = mem[t_addr[g][5:2]];
                end
                exp_q[g].push_back(e);
            end else begin
                check("strobe_idle", 64'({DM_read, DM_write}), 64'(0));
                check("addr_hold", 64'(DM_address), 64'(last_addr));
                check("din_hold", 64'(DM_in), 64'(last_din));
            end
            check("ack_onehot", 64'(m0_ack & m1_ack), 64'(0));
            for (int m = 0; m < 2; m++) begin
                if (ack_of(m)) begin
                    check("ack_expected", 64'(exp_q[m].size() != 0), 64'(1));
                    if (exp_q[m].size() != 0) begin
                        e = exp_q[m].pop_front();
                        check("ack_cycle", 64'(cyc), 64'(e.ack_cyc));
                        check("err", 64'(err_of(m)), 64'(e.err));
                        check("rdata", 64'(rdata_of(m)), 64'(e.rdata));
                        model_rdata[m] = e.rdata;
                        model_err[m]   = e.err;
                    end
                end else begin
                    if (exp_q[m].size() != 0 && cyc > exp_q[m][0].ack_cyc) begin
                        check("ack_missing", 64'(cyc), 64'(exp_q[m][0].ack_cyc));
                        void'(exp_q[m].pop_front());
                    end
                    check("rdata_hold", 64'(rdata_of(m)), 64'(model_rdata[m]));
                    check("err_hold", 64'(err_of(m)), 64'(model_err[m]));
                end
            end
        end
        prev_req = req;
    end

    task automatic txn(input int m, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic drop);
        bit done = 0;
        int n    = 0;
        @(posedge clock);
        #1;
        t_wr[m] = w; t_addr[m] = a; t_wd[m] = d; issued[m] = 1'b0;
        wr[m] = w;   ad[m] = a;     wd[m] = d;   req[m] = 1'b1;
        while (!done) begin
            @(negedge clock);
            n++;
            if (reset || ack_of(m)) begin
                done = 1;
            end else if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL txn_timeout master %0d: no ack after %0d cycles", m, n);
                done = 1;
            end else if (drop && issued[m] && req[m]) begin
                @(posedge clock);
                #1;
                req[m] = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        req[m] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [DW-1:0] r0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int m = 0; m < 2; m++) begin
            ad[m] = '0; wd[m] = '0; issued[m] = 1'b0;
            t_wr[m] = 1'b0; t_addr[m] = '0; t_wd[m] = '0;
            model_rdata[m] = '0; model_err[m] = 1'b0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Simultaneous requests right after reset: m0, m1, m0.
        grant_log.delete();
        fork
            begin
                txn(0, 1'b1, 12'h040, 32'h1111_0000, 1'b0);
                txn(0, 1'b1, 12'h044, 32'h1111_0001, 1'b0);
            end
            txn(1, 1'b1, 12'h048, 32'h2222_0000, 1'b0);
        join
        check("rr_count", 64'(grant_log.size()), 64'(3));
        if (grant_log.size() == 3) begin
            check("rr_first", 64'(grant_log[0]), 64'(0));
            check("rr_second", 64'(grant_log[1]), 64'(1));
            check("rr_third", 64'(grant_log[2]), 64'(0));
        end

        txn(0, 1'b1, 12'h010, 32'hDEAD_BEEF, 1'b0);
        force_k = 4;
        txn(1, 1'b0, 12'h010, 32'h0, 1'b0);
        check("m1_read_back", 64'(m1_rdata), 64'(32'hDEAD_BEEF));
        check("m1_read_err", 64'(m1_err), 64'(0));

        // Memory never answers: read must time out with rdata untouched.
        r0      = m0_rdata;
        force_k = 0;
        txn(0, 1'b0, 12'h020, 32'h0, 1'b0);
        check("tmo_err", 64'(m0_err), 64'(1));
        check("tmo_rdata", 64'(m0_rdata), 64'(r0));

        force_k = -1;
        txn(1, 1'b1, 12'h030, 32'hCAFE_F00D, 1'b1);
        txn(1, 1'b0, 12'h030, 32'h0, 1'b1);
        check("drop_read", 64'(m1_rdata), 64'(32'hCAFE_F00D));

        // Reset in the middle of a stalled read.
        force_k = 0;
        fork
            txn(0, 1'b0, 12'h024, 32'h0, 1'b0);
        join_none
        for (int i = 0; i < 50 && !issued[0]; i++) @(negedge clock);
        check("rst_issue_seen", 64'(issued[0]), 64'(1));
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        wait fork;
        force_k = 3;
        txn(0, 1'b0, 12'h010, 32'h0, 1'b0);
        check("post_rst_read", 64'(m0_rdata), 64'(32'hDEAD_BEEF));
        check("post_rst_err", 64'(m0_err), 64'(0));

        force_k = -1;
        fork
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clock);
                txn(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15) << 2),
                    $urandom, 1'($urandom_range(0, 7) == 0));
            end
            for (int j = 0; j < 30; j++) begin
                repeat ($urandom_range(0, 3)) @(posedge clock);
                txn(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15) << 2),
                    $urandom, 1'($urandom_range(0, 7) == 0));
            end
        join
        repeat (5) @(posedge clock);
        check("drain_q0", 64'(exp_q[0].size()), 64'(0));
        check("drain_q1", 64'(exp_q[1].size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter data_size, default 32, data width of both masters and the memory port.
REQ-002 Parameter addr_bit, default 12, byte-address width of both masters and the memory port.
REQ-003 Parameter WR_LAT, default 3, cycles spent in WAIT_WR before a write is acknowledged.
REQ-004 Parameter TIMEOUT, default 15, maximum WAIT_RD cycles before a read is aborted.
REQ-005 clock  input  1  system clock; all state changes on posedge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 m0_req  input  1  master 0 request; held until m0_ack.
REQ-008 m0_write  input  1  master 0 direction: 1 = write, 0 = read.
REQ-009 m0_addr  input  addr_bit  master 0 byte address.
REQ-010 m0_wdata  input  data_size  master 0 write data.
REQ-011 m0_rdata  output  data_size  master 0 read data, valid while m0_ack is 1.
REQ-012 m0_ack  output  1  one-cycle completion pulse for master 0.
REQ-013 m0_err  output  1  qualifies m0_ack: read timed out.
REQ-014 m1_req, m1_write, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: identical to the m0 ports, for master 1.
REQ-015 DM_enable  output  1  memory enable.
REQ-016 DM_read  output  1  memory read strobe.
REQ-017 DM_write  output  1  memory write strobe.
REQ-018 DM_address  output  addr_bit  byte address to memory, passed unmodified.
REQ-019 DM_in  output  data_size  write data to memory.
REQ-020 DM_out  input  data_size  read data from memory.
REQ-021 DM_ready  input  1  memory read-complete flag; 0 while a read is in flight.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT_RD, WAIT_WR and DONE.
REQ-023 IDLE SHALL grant when any req is 1: a lone requester wins; if both request, the master not granted last wins (round-robin pointer, 1 bit).
REQ-024 On grant, the block SHALL capture the granted master's write, addr and wdata into internal registers, update the pointer to the granted master, and enter ISSUE.
REQ-025 ISSUE SHALL last exactly one cycle: DM_enable=1, DM_read=~write, DM_write=write, DM_address and DM_in from the captured registers; next state WAIT_RD for a read, WAIT_WR for a write.
REQ-026 In all states other than ISSUE, DM_enable, DM_read and DM_write SHALL be 0; DM_address and DM_in SHALL hold their last values.
REQ-027 WAIT_RD SHALL ignore DM_ready in its first cycle; from the second cycle on, DM_ready=1 SHALL latch DM_out into the granted master's rdata, clear err, and go to DONE.
REQ-028 WAIT_RD SHALL count its cycles; if TIMEOUT cycles elapse without an accepted DM_ready, it SHALL set the granted master's err, leave rdata unchanged, and go to DONE.
REQ-029 WAIT_WR SHALL last exactly WR_LAT cycles, clear err, then go to DONE.
REQ-030 DONE SHALL last one cycle, pulse only the granted master's ack, then return to IDLE.
REQ-031 Grant-to-ack latency: write = 1 (ISSUE) + WR_LAT + 1 (DONE) cycles after the grant edge; read = 2 + (WAIT_RD cycles).
REQ-032 A req deasserted after grant SHALL NOT abort the transaction; ack is still pulsed.
REQ-033 Requests arriving in any non-IDLE state SHALL wait; no request is lost while its req stays high.
REQ-034 rdata and err SHALL hold their values until that master's next completion.
REQ-035 Back-to-back: with both reqs held continuously, grants SHALL alternate m0, m1, m0, ...

Reset
REQ-036 While reset=1: state=IDLE, pointer set so m0 wins the first tie, both ack=0, both err=0, both rdata=0, DM_enable/DM_read/DM_write=0, DM_address=0, DM_in=0, counters=0.
REQ-037 Reset asserted mid-transaction SHALL abandon it with no ack; the memory-side strobes drop in the same cycle.

Verification
REQ-038 m0 write addr 0x010 data 0xDEADBEEF, WR_LAT=3 -> one DM_write cycle with DM_address=0x010, DM_in=0xDEADBEEF; m0_ack pulses 5 cycles after grant.
REQ-039 m1 read addr 0x010 with the memory holding 0xDEADBEEF -> m1_rdata=0xDEADBEEF, m1_err=0, m1_ack on the cycle after DM_ready returns to 1.
REQ-040 m0 and m1 request simultaneously after reset, both held -> grant order m0, m1, m0; each ack is a single cycle.
REQ-041 Read with DM_ready forced 0 -> m0_ack and m0_err both 1 after TIMEOUT WAIT_RD cycles; m0_rdata unchanged.
REQ-042 Reset asserted during WAIT_RD -> no ack; all outputs at reset values next cycle; a subsequent read completes normally.
REQ-043 m1 drops req in the cycle after grant -> the transaction still completes and m1_ack pulses once.
